// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the processor controller, the data RAM and
// the data-memory arbiter.
//   DMEM_AW / DMEM_DW : data memory address / word width
//   arb_state_t       : arbiter FSM states
//   OWN_*             : encoding of the arbiter's owner output
package proc_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_CPU = 2'd1,
    LOCK_DMA = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

endpackage

// File: rtl/dmem_rd_return.sv
// dmem_rd_return: steers the synchronous RAM's read data back to the port
// whose read was granted one cycle earlier.
//   Clk, Rst            clock, synchronous active-high reset
//   rd_req              a read was granted this cycle
//   rd_tag              port of that read: 0 = CPU, 1 = DMA
//   mem_rdata           RAM read data (valid one cycle after the grant)
//   cpu_rvalid/rdata    CPU read return
//   dma_rvalid/rdata    DMA read return
module dmem_rd_return
  import proc_pkg::*;
#(
  parameter int DW = DMEM_DW
)(
  input  logic          Clk,
  input  logic          Rst,
  input  logic          rd_req,
  input  logic          rd_tag,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata
);

  logic          rd_flag_reg;
  logic          rd_tag_reg;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata [2];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_flag_reg <= 1'b0;
      rd_tag_reg  <= 1'b0;
    end else begin
      rd_flag_reg <= rd_req;
      rd_tag_reg  <= rd_tag;
    end
  end

  // Masking with Rst kills a read that was in flight when reset arrived.
  assign rvalid = {rd_tag_reg, ~rd_tag_reg} & {2{rd_flag_reg & ~Rst}};

  // Index 0 = CPU, 1 = DMA. Data passes straight through in the rvalid
  // cycle and is captured so the port keeps seeing it afterwards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DW-1:0] hold_reg;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          hold_reg <= '0;
        end else if (rvalid[gi]) begin
          hold_reg <= mem_rdata;
        end
      end

      assign rdata[gi] = rvalid[gi] ? mem_rdata : hold_reg;
    end
  endgenerate

  assign cpu_rvalid = rvalid[0];
  assign cpu_rdata  = rdata[0];
  assign dma_rvalid = rvalid[1];
  assign dma_rdata  = rdata[1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the processor
// controller (CPU port) and the DMA/debug loader (DMA port).
//   Clk, Rst                        clock, synchronous active-high reset
//   cpu_req/we/lock/addr/wdata      CPU request
//   cpu_gnt/rvalid/rdata            CPU grant and read return
//   dma_req/we/lock/addr/wdata      DMA request
//   dma_gnt/rvalid/rdata            DMA grant and read return
//   mem_addr/we/wdata, mem_rdata    RAM side (synchronous read, 1 cycle)
//   owner                           this cycle's grant (OWN_NONE/CPU/DMA)
//   lock_err                        pulse after a lock was force-released
// Grants are combinational from requests and registered state. A port
// holding lock keeps exclusive ownership until it drops req or lock, or
// until LOCK_MAX consecutive locked grants have been issued. A DMA waiting
// WAIT_MAX cycles beats the CPU in a tie.
// Build option: DMEM_ARB_RR_EN makes idle ties alternate round-robin.
module dmem_arbiter
  import proc_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int WAIT_MAX = 4,
  parameter int LOCK_MAX = 8
)(
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_lock,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic          lock_err
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [WW-1:0] WAIT_MAX_C = WW'(WAIT_MAX);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

  arb_state_t    state_reg, state_next;
  logic [CW-1:0] lock_cnt_reg, lock_cnt_next;
  logic [WW-1:0] dma_wait_reg, dma_wait_next;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic          lock_err_reg;
  logic          lock_rel;
  logic          cpu_hold, dma_hold;
  logic          cpu_win, dma_win;
`ifdef DMEM_ARB_RR_EN
  logic [1:0]    last_winner_reg;
`endif

  // Arbitration and lock bookkeeping
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    lock_rel      = 1'b0;
    cpu_win       = 1'b0;
    dma_win       = 1'b0;

    // A lock continues only while its owner keeps both req and lock high;
    // otherwise this cycle is arbitrated exactly as from IDLE.
    cpu_hold = (state_reg == LOCK_CPU) && cpu_req && cpu_lock;
    dma_hold = (state_reg == LOCK_DMA) && dma_req && dma_lock;

    if (cpu_hold) begin
      cpu_win = 1'b1;
    end else if (dma_hold) begin
      dma_win = 1'b1;
    end else if (cpu_req && dma_req) begin
      if (dma_wait_reg == WAIT_MAX_C) begin
        dma_win = 1'b1;
`ifdef DMEM_ARB_RR_EN
      end else if (last_winner_reg == OWN_CPU) begin
        dma_win = 1'b1;
`endif
      end else begin
        cpu_win = 1'b1;
      end
    end else begin
      cpu_win = cpu_req;
      dma_win = dma_req;
    end

    if (Rst) begin
      cpu_win = 1'b0;
      dma_win = 1'b0;
    end

    // A fresh locked grant starts the count at 1; a continuing one adds 1.
    if (cpu_win && cpu_lock) begin
      state_next    = LOCK_CPU;
      lock_cnt_next = cpu_hold ? lock_cnt_reg + 1'b1 : CW'(1);
    end else if (dma_win && dma_lock) begin
      state_next    = LOCK_DMA;
      lock_cnt_next = dma_hold ? lock_cnt_reg + 1'b1 : CW'(1);
    end else begin
      state_next    = IDLE;
      lock_cnt_next = '0;
    end

    if (lock_cnt_next == LOCK_MAX_C) begin
      state_next    = IDLE;
      lock_cnt_next = '0;
      lock_rel      = 1'b1;
    end
  end

  // DMA starvation counter, saturating
  always_comb begin
    dma_wait_next = dma_wait_reg;
    if (!dma_req || dma_win) begin
      dma_wait_next = '0;
    end else if (dma_wait_reg != WAIT_MAX_C) begin
      dma_wait_next = dma_wait_reg + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= IDLE;
      lock_cnt_reg  <= '0;
      dma_wait_reg  <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      lock_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lock_cnt_reg  <= lock_cnt_next;
      dma_wait_reg  <= dma_wait_next;
      mem_addr_reg  <= mem_addr;
      mem_wdata_reg <= mem_wdata;
      lock_err_reg  <= lock_rel;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Starts as DMA so that the CPU takes the first tie.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_winner_reg <= OWN_DMA;
    end else if (cpu_win) begin
      last_winner_reg <= OWN_CPU;
    end else if (dma_win) begin
      last_winner_reg <= OWN_DMA;
    end
  end
`endif

  // RAM mux; address and data park on their last value when idle.
  assign mem_addr  = cpu_win ? cpu_addr  : (dma_win ? dma_addr  : mem_addr_reg);
  assign mem_wdata = cpu_win ? cpu_wdata : (dma_win ? dma_wdata : mem_wdata_reg);
  assign mem_we    = (cpu_win & cpu_we) | (dma_win & dma_we);

  assign cpu_gnt  = cpu_win;
  assign dma_gnt  = dma_win;
  assign owner    = cpu_win ? OWN_CPU : (dma_win ? OWN_DMA : OWN_NONE);
  assign lock_err = lock_err_reg;

  dmem_rd_return #(
    .DW (DW)
  ) u_rd_return (
    .Clk        (Clk),
    .Rst        (Rst),
    .rd_req     ((cpu_win & ~cpu_we) | (dma_win & ~dma_we)),
    .rd_tag     (dma_win),
    .mem_rdata  (mem_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test of dmem_arbiter against a behavioural
// synchronous 256x16 RAM. Inputs change 1 time unit after a rising edge;
// outputs are checked 3 units later, before the falling edge.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_we, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;
  logic          lock_err;

  logic [DW-1:0] ram [256];

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .WAIT_MAX (4),
    .LOCK_MAX (8)
  ) dut (
    .Clk        (clk),
    .Rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .owner      (owner),
    .lock_err   (lock_err)
  );

  // Behavioural synchronous RAM, read-before-write
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  // Bound on total run time
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    ram[8'h10] = 16'h1234;
    ram[8'h20] = 16'hBEEF;
    rst = 1;
    idle_inputs();
    next_cycle();
    do_reset();

    // Reset state
    #3;
    chk("rst.cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst.dma_gnt", 32'(dma_gnt), 0);
    chk("rst.owner", 32'(owner), 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.mem_addr", 32'(mem_addr), 0);
    chk("rst.cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst.lock_err", 32'(lock_err), 0);

    // CPU-only read of 0x10
    next_cycle();
    cpu_req = 1; cpu_addr = 8'h10;
    #3;
    chk("rd.cpu_gnt", 32'(cpu_gnt), 1);
    chk("rd.owner", 32'(owner), 1);
    chk("rd.mem_addr", 32'(mem_addr), 32'h10);
    next_cycle();
    cpu_req = 0; cpu_addr = 8'h55;
    #3;
    chk("rd.cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("rd.cpu_rdata", 32'(cpu_rdata), 32'h1234);
    chk("rd.owner_idle", 32'(owner), 0);
    next_cycle();
    #3;
    chk("rd.rvalid_drop", 32'(cpu_rvalid), 0);
    chk("rd.rdata_hold", 32'(cpu_rdata), 32'h1234);
    chk("rd.addr_hold", 32'(mem_addr), 32'h10);

    // Continuous contention, no locks
    do_reset();
    cpu_req = 1; cpu_addr = 8'h01;
    dma_req = 1; dma_addr = 8'h02;
    for (int i = 0; i < 5; i++) begin
`ifdef DMEM_ARB_RR_EN
      logic exp_cpu;
      exp_cpu = (i % 2 == 0);
`else
      logic exp_cpu;
      exp_cpu = (i < 4);
`endif
      #3;
      chk($sformatf("cont[%0d].cpu_gnt", i), 32'(cpu_gnt), 32'(exp_cpu));
      chk($sformatf("cont[%0d].dma_gnt", i), 32'(dma_gnt), 32'(!exp_cpu));
      next_cycle();
    end
    idle_inputs();
`ifndef DMEM_ARB_RR_EN
    chk("cont.dma_wait", 32'(dut.dma_wait_reg), 0);
`endif

    // Two-cycle CPU lock while DMA waits
    do_reset();
    cpu_req = 1; cpu_lock = 1; cpu_addr = 8'h03;
    dma_req = 1; dma_addr = 8'h20;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk($sformatf("lk2[%0d].cpu_gnt", i), 32'(cpu_gnt), 1);
      chk($sformatf("lk2[%0d].dma_gnt", i), 32'(dma_gnt), 0);
      next_cycle();
    end
    cpu_req = 0; cpu_lock = 0;
    #3;
    chk("lk2.dma_gnt", 32'(dma_gnt), 1);
    chk("lk2.owner", 32'(owner), 2);
    chk("lk2.lock_err", 32'(lock_err), 0);
    next_cycle();
    dma_req = 0;
    #3;
    chk("lk2.dma_rvalid", 32'(dma_rvalid), 1);
    chk("lk2.dma_rdata", 32'(dma_rdata), 32'hBEEF);

    // Lock held past LOCK_MAX
    do_reset();
    cpu_req = 1; cpu_lock = 1; cpu_addr = 8'h04;
    dma_req = 1; dma_addr = 8'h05;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk($sformatf("lkmax[%0d].cpu_gnt", i), 32'(cpu_gnt), 32'(i != 8));
      chk($sformatf("lkmax[%0d].dma_gnt", i), 32'(dma_gnt), 32'(i == 8));
      chk($sformatf("lkmax[%0d].lock_err", i), 32'(lock_err), 32'(i == 8));
      next_cycle();
    end

    // CPU write then DMA read-back of the same word
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'hA5A5;
    #3;
    chk("wr.mem_we", 32'(mem_we), 1);
    chk("wr.mem_wdata", 32'(mem_wdata), 32'hA5A5);
    next_cycle();
    idle_inputs();
    dma_req = 1; dma_addr = 8'h30;
    #3;
    chk("wr.no_rvalid", 32'(cpu_rvalid), 0);
    chk("wr.dma_gnt", 32'(dma_gnt), 1);
    chk("wr.mem_we_rd", 32'(mem_we), 0);
    next_cycle();
    dma_req = 0;
    #3;
    chk("wr.dma_rdata", 32'(dma_rdata), 32'hA5A5);

    // Reset in the cycle after a DMA read grant
    next_cycle();
    dma_req = 1; dma_addr = 8'h20;
    #3;
    chk("rstrd.dma_gnt", 32'(dma_gnt), 1);
    next_cycle();
    dma_req = 0; rst = 1;
    #3;
    chk("rstrd.rvalid_in_rst", 32'(dma_rvalid), 0);
    next_cycle();
    rst = 0;
    #3;
    chk("rstrd.dma_rvalid", 32'(dma_rvalid), 0);
    chk("rstrd.dma_rdata", 32'(dma_rdata), 0);
    chk("rstrd.cpu_rdata", 32'(cpu_rdata), 0);
    chk("rstrd.mem_addr", 32'(mem_addr), 0);
    chk("rstrd.mem_wdata", 32'(mem_wdata), 0);
    chk("rstrd.owner", 32'(owner), 0);
    chk("rstrd.lock_err", 32'(lock_err), 0);
    next_cycle();
    #3;
    chk("rstrd.rvalid_late", 32'(dma_rvalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
